// File: rtl/dmem_wait_state_slave.sv
// Data-memory slave with a fixed, parameterised wait-state latency.
// Requests are accepted in IDLE only. Each request is answered by a one-cycle ready/err pulse.
module dmem_wait_state_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr,
  input  logic [DATA_WIDTH-1:0]   dmem_wdata,
  input  logic [DATA_WIDTH/8-1:0] dmem_wstrb,
  input  logic                    dmem_write_i,
  input  logic                    dmem_read_i,
  output logic [DATA_WIDTH-1:0]   dmem_rdata,
  output logic                    dmem_ready_o,
  output logic                    err_o,
  output logic                    busy_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = (STRB_W > 1) ? $clog2(STRB_W) : 0;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       wstrb_q;
  logic                    wr_q;
  logic                    rd_q;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    capture_s;
  logic                    enter_resp_s;
  logic [ADDR_WIDTH-1:0]   req_addr_s;
  logic [DATA_WIDTH-1:0]   req_wdata_s;
  logic [STRB_W-1:0]       req_wstrb_s;
  logic                    req_wr_s;
  logic                    req_rd_s;
  logic [IDX_W-1:0]        req_idx_s;
  logic                    in_range_s;
  logic                    mem_we_s;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) begin
        res[b*8 +: 8] = new_word[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_word[b*8 +: 8];
      end
    end
    return res;
  endfunction

  // Sequencing: accept in IDLE, count down in WAIT, one RESP cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    capture_s    = 1'b0;
    enter_resp_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dmem_read_i || dmem_write_i) begin
          capture_s = 1'b1;
          cnt_d     = CNT_INIT;
          if (LATENCY == 1) begin
            state_d      = ST_RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d        = 4'd0;
          state_d      = ST_RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // With LATENCY=1 the response is formed on the capture edge, so take the live inputs then.
  always_comb begin
    if (capture_s) begin
      req_addr_s  = dmem_addr;
      req_wdata_s = dmem_wdata;
      req_wstrb_s = dmem_wstrb;
      req_wr_s    = dmem_write_i;
      req_rd_s    = dmem_read_i;
    end else begin
      req_addr_s  = addr_q;
      req_wdata_s = wdata_q;
      req_wstrb_s = wstrb_q;
      req_wr_s    = wr_q;
      req_rd_s    = rd_q;
    end
  end

  assign req_idx_s  = req_addr_s[OFF_W +: IDX_W];
  assign in_range_s = ((req_addr_s >> (OFF_W + IDX_W)) == {ADDR_WIDTH{1'b0}});
  assign mem_we_s   = enter_resp_s && req_wr_s && in_range_s;

  // Response outputs, registered so they appear for exactly the RESP cycle.
  always_comb begin
    ready_d = enter_resp_s;
    busy_d  = (state_d != ST_IDLE);
    err_d   = 1'b0;
    rdata_d = {DATA_WIDTH{1'b0}};
    if (enter_resp_s) begin
      err_d = !in_range_s || (req_wr_s && req_rd_s);
      if (in_range_s && req_rd_s && !req_wr_s) begin
        rdata_d = mem_q[req_idx_s];
      end else begin
        rdata_d = {DATA_WIDTH{1'b0}};
      end
    end else begin
      err_d = 1'b0;
    end
  end

  // State, counter, captured request and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      wdata_q <= {DATA_WIDTH{1'b0}};
      wstrb_q <= {STRB_W{1'b0}};
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
      if (capture_s) begin
        addr_q  <= dmem_addr;
        wdata_q <= dmem_wdata;
        wstrb_q <= dmem_wstrb;
        wr_q    <= dmem_write_i;
        rd_q    <= dmem_read_i;
      end
    end
  end

  // Storage array; cleared entirely by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (mem_we_s) begin
      mem_q[req_idx_s] <= merge_bytes(mem_q[req_idx_s], req_wdata_s, req_wstrb_s);
    end
  end

  assign dmem_ready_o = ready_q;
  assign err_o        = err_q;
  assign busy_o       = busy_q;
  assign dmem_rdata   = rdata_q;

endmodule

// File: tb/tb_dmem_wait_state_slave.sv
// Directed vector bench for dmem_wait_state_slave (DEPTH=64, LATENCY=2, 32-bit data).
module tb_dmem_wait_state_slave;

  logic        clk;
  logic        rst_n;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_write_i;
  logic        dmem_read_i;
  logic [31:0] dmem_rdata;
  logic        dmem_ready_o;
  logic        err_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  dmem_wait_state_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(64), .LATENCY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_write_i(dmem_write_i), .dmem_read_i(dmem_read_i),
    .dmem_rdata(dmem_rdata), .dmem_ready_o(dmem_ready_o),
    .err_o(err_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    dmem_read_i  = 1'b0;
    dmem_write_i = 1'b0;
    dmem_addr    = 32'h0;
    dmem_wdata   = 32'h0;
    dmem_wstrb   = 4'h0;
  endtask

  // Called at a negedge; drives one request and checks the full response window.
  task automatic do_txn(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic [31:0] exp_rdata, input logic exp_err);
    dmem_read_i  = rd;
    dmem_write_i = wr;
    dmem_addr    = addr;
    dmem_wdata   = wdata;
    dmem_wstrb   = wstrb;
    @(negedge clk);
    idle_inputs();
    chk({tag, "_wait_ready"}, {31'h0, dmem_ready_o}, 32'h0);
    chk({tag, "_wait_busy"}, {31'h0, busy_o}, 32'h1);
    @(negedge clk);
    chk({tag, "_ready"}, {31'h0, dmem_ready_o}, 32'h1);
    chk({tag, "_err"}, {31'h0, err_o}, {31'h0, exp_err});
    chk({tag, "_rdata"}, dmem_rdata, exp_rdata);
    chk({tag, "_resp_busy"}, {31'h0, busy_o}, 32'h1);
    @(negedge clk);
    chk({tag, "_post_ready"}, {31'h0, dmem_ready_o}, 32'h0);
    chk({tag, "_post_busy"}, {31'h0, busy_o}, 32'h0);
    chk({tag, "_post_rdata"}, dmem_rdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ready_cnt;
    int busy_cnt;
    logic [31:0] seen_rdata;

    //             rd    wr    addr          wdata         strb  exp_rdata     err
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0022, 32'hAABB_CCDD, 4'h5, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0, 32'h11BB_33DD, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0004, 32'h0000_0005, 4'hF, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 4'h0, 32'h0000_0005, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0030, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0030, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 32'h8000_0010, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 32'h0000_00FC, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 32'h0000_00FC, 32'h0000_0000, 4'h0, 32'h1234_5678, 1'b0};

    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", {31'h0, dmem_ready_o}, 32'h0);
    chk("rst_err", {31'h0, err_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_rdata", dmem_rdata, 32'h0);

    // Release reset and present the first request in the same cycle.
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
             vecs[i].wdata, vecs[i].wstrb, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Follow-up requests held through WAIT and RESP must be ignored.
    dmem_read_i = 1'b1;
    dmem_addr   = 32'h0000_0010;
    @(negedge clk);
    idle_inputs();
    dmem_write_i = 1'b1;
    dmem_addr    = 32'h0000_0040;
    dmem_wdata   = 32'h0000_CAFE;
    dmem_wstrb   = 4'hF;
    ready_cnt  = 0;
    busy_cnt   = 1;
    seen_rdata = 32'h0;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) idle_inputs();
      if (c > 0) begin
        if (busy_o) busy_cnt++;
        if (dmem_ready_o) begin
          ready_cnt++;
          seen_rdata = dmem_rdata;
        end
      end
      @(negedge clk);
    end
    chk("ign_ready_pulses", ready_cnt, 32'd1);
    chk("ign_busy_cycles", busy_cnt, 32'd2);
    chk("ign_rdata", seen_rdata, 32'hDEAD_BEEF);
    do_txn("ign_no_write", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'h0, 1'b0);

    // Reset in the middle of a write's WAIT state aborts it.
    dmem_write_i = 1'b1;
    dmem_addr    = 32'h0000_0008;
    dmem_wdata   = 32'h0000_0077;
    dmem_wstrb   = 4'hF;
    @(negedge clk);
    idle_inputs();
    chk("mid_busy_before", {31'h0, busy_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy_async", {31'h0, busy_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ready_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (dmem_ready_o) ready_cnt++;
    end
    chk("mid_no_ready", ready_cnt, 32'd0);
    do_txn("mid_read8", 1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'h0, 32'h0, 1'b0);
    do_txn("mid_mem_clr", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
